// File: rtl/csoc_scan_responder_pkg.sv
// csoc_resp_pkg: shared types and constants for the CSoC scan responder.
// FSM encoding, synchronizer depth and response increment.
package csoc_resp_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_RESP = 2'd2
  } fstate_e;

  localparam int SYNC_DEPTH = 2;

  localparam logic [7:0] RESP_INC = 8'h01;

endpackage

// File: rtl/csoc_scan_responder_scan_lane.sv
// scan_lane: one scan chain with shift, invert-capture and clear.
// chain[0] takes sin_i on shift; tail_o is the last bit.
module scan_lane #(
  parameter int LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic shift_i,
  input  logic cap_i,
  input  logic sin_i,
  output logic tail_o
);

  logic [LEN-1:0] chain_q;
  logic [LEN-1:0] chain_d;

  // Clear wins over shift, shift over capture.
  always_comb begin
    chain_d = chain_q;
    if (clr_i)
      chain_d = '0;
    else if (shift_i)
      chain_d = {chain_q[LEN-2:0], sin_i};
    else if (cap_i)
      chain_d = ~chain_q;
  end

  // Chain storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end

  assign tail_o = chain_q[LEN-1];

endmodule

// File: rtl/csoc_scan_responder.sv
// csoc_scan_responder: chip-side stand-in for the CSoC tester port.
// CSOC_RESP_SHIFT_CNT_EN adds shift_cnt_o, a saturating shift counter.
module csoc_scan_responder
  import csoc_resp_pkg::*;
#(
  parameter int CHAIN_LEN  = 16,
  parameter int RESP_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       csoc_clk_i,
  input  logic       csoc_rstn_i,
  input  logic       csoc_test_se_i,
  input  logic       csoc_test_tm_i,
  input  logic       csoc_uart_read_i,
  input  logic [7:0] csoc_data_i,
`ifdef CSOC_RESP_SHIFT_CNT_EN
  output logic [15:0] shift_cnt_o,
`endif
  output logic       csoc_uart_write_o,
  output logic [7:0] csoc_data_o
);

  localparam int SW = 13;
  localparam int CW =
    (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

  logic [SW-1:0] sync_q [SYNC_DEPTH];
  logic [SW-1:0] in_vec;
  logic [SW-1:0] sy;

  assign in_vec = {csoc_clk_i, csoc_rstn_i,
                   csoc_test_se_i, csoc_test_tm_i,
                   csoc_uart_read_i, csoc_data_i};

  // Two-stage synchronizer for every tester input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_DEPTH; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_vec;
      for (int i = 1; i < SYNC_DEPTH; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sy = sync_q[SYNC_DEPTH-1];

  logic [7:0] data_s;
  logic       rd_s, tm_s, se_s;
  logic       rstn_s, sclk_s;

  assign data_s = sy[7:0];
  assign rd_s   = sy[8];
  assign tm_s   = sy[9];
  assign se_s   = sy[10];
  assign rstn_s = sy[11];
  assign sclk_s = sy[12];

  logic sclk_p_q, rd_p_q;

  // Previous synced values for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_p_q <= 1'b0;
      rd_p_q   <= 1'b0;
    end else begin
      sclk_p_q <= sclk_s;
      rd_p_q   <= rd_s;
    end
  end

  logic sclk_edge, rd_edge;
  logic shift_en, cap_en;

  assign sclk_edge = sclk_s & ~sclk_p_q;
  assign rd_edge   = rd_s & ~rd_p_q;
  assign shift_en  = sclk_edge & tm_s & se_s & rstn_s;
  assign cap_en    = sclk_edge & tm_s & ~se_s & rstn_s;

  logic [7:0] tail;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    scan_lane #(
      .LEN(CHAIN_LEN)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (~rstn_s),
      .shift_i(shift_en),
      .cap_i  (cap_en),
      .sin_i  (data_s[k]),
      .tail_o (tail[k])
    );
  end

  fstate_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    req_q, req_d;

  // FSM state, delay counter and request byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= F_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next state; chip reset and scan mode force idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    if (!rstn_s) begin
      state_d = F_IDLE;
      cnt_d   = '0;
      req_d   = '0;
    end else if (tm_s) begin
      state_d = F_IDLE;
    end else begin
      case (state_q)
        F_IDLE:
          if (rd_edge) begin
            req_d   = data_s;
            cnt_d   = CW'(RESP_DELAY - 1);
            state_d = F_WAIT;
          end
        F_WAIT:
          if (cnt_q == '0) state_d = F_RESP;
          else             cnt_d = cnt_q - CW'(1);
        F_RESP:
          state_d = F_IDLE;
        default:
          state_d = F_IDLE;
      endcase
    end
  end

  logic       write_q, write_d;
  logic [7:0] resp_q, resp_d;
  logic [7:0] scan_q;
  logic       fire;

  // Response fires once from F_RESP unless aborted.
  always_comb begin
    fire    = (state_q == F_RESP) & ~tm_s & rstn_s;
    write_d = fire;
    resp_d  = resp_q;
    if (!rstn_s)   resp_d = '0;
    else if (fire) resp_d = req_q + RESP_INC;
  end

  // Registered strobe, response byte and scan tails.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      resp_q  <= '0;
      scan_q  <= '0;
    end else begin
      write_q <= write_d;
      resp_q  <= resp_d;
      scan_q  <= rstn_s ? tail : 8'h00;
    end
  end

  assign csoc_uart_write_o = write_q;
  assign csoc_data_o = tm_s ? scan_q : resp_q;

`ifdef CSOC_RESP_SHIFT_CNT_EN
  logic [15:0] scnt_q;

  // Saturating count of shift edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scnt_q <= '0;
    else if (!rstn_s)
      scnt_q <= '0;
    else if (shift_en && scnt_q != 16'hFFFF)
      scnt_q <= scnt_q + 16'd1;
  end

  assign shift_cnt_o = scnt_q;
`endif

endmodule

// File: tb/tb_csoc_scan_responder.sv
// tb_csoc_scan_responder: scoreboard bench for the scan responder.
// Scan tails and response bytes are predicted by a bench-side model.
module tb_csoc_scan_responder;

  localparam int RESP_DELAY = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       csoc_clk;
  logic       rstn;
  logic       se;
  logic       tm;
  logic       rd;
  logic [7:0] din;
  logic       write_o;
  logic [7:0] dout;
`ifdef CSOC_RESP_SHIFT_CNT_EN
  logic [15:0] scnt;
`endif

  csoc_scan_responder #(
    .CHAIN_LEN (16),
    .RESP_DELAY(RESP_DELAY)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .csoc_clk_i       (csoc_clk),
    .csoc_rstn_i      (rstn),
    .csoc_test_se_i   (se),
    .csoc_test_tm_i   (tm),
    .csoc_uart_read_i (rd),
    .csoc_data_i      (din),
`ifdef CSOC_RESP_SHIFT_CNT_EN
    .shift_cnt_o      (scnt),
`endif
    .csoc_uart_write_o(write_o),
    .csoc_data_o      (dout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  scan_q[$];
  logic [15:0] mdl [8];

  always @(posedge clk) cyc++;

  // Response monitor: every write strobe pops one expected byte.
  always @(negedge clk) begin
    if (write_o === 1'b1) begin
      wr_cnt++;
      wr_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: data_o=%h, none expected",
                 dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL resp: data_o=%h expected %h", dout, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  function automatic void mdl_clear();
    for (int k = 0; k < 8; k++) mdl[k] = '0;
  endfunction

  function automatic void mdl_step();
    logic [7:0] e;
    for (int k = 0; k < 8; k++) begin
      if (tm && se) mdl[k] = {mdl[k][14:0], din[k]};
      else if (tm)  mdl[k] = ~mdl[k];
      e[k] = mdl[k][15];
    end
    scan_q.push_back(e);
  endfunction

  task automatic csoc_pulse();
    mdl_step();
    @(posedge clk); #1 csoc_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 csoc_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic unload(input string nm, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      csoc_pulse();
      e = scan_q.pop_front();
      tests++;
      if (dout !== e) begin
        fails++;
        $display("FAIL %s[%0d]: data_o=%h expected %h",
                 nm, i, dout, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; csoc_clk = 1'b0; rstn = 1'b1;
    se = 1'b0; tm = 1'b0; rd = 1'b0; din = 8'h00;
    mdl_clear();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (write_o !== 1'b0 || dout !== 8'h00) begin
      fails++;
      $display("FAIL reset: write_o=%b data_o=%h expected 0/00",
               write_o, dout);
    end
    rst = 1'b0;
    tm = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (dout !== 8'h00) begin
      fails++;
      $display("FAIL reset_scan: data_o=%h expected 00", dout);
    end
  endtask

  task automatic test_shift();
    logic [7:0] e;
    tm = 1'b1; se = 1'b1; din = 8'hA5;
    unload("shift", 15);
    // Last pulse: chain moves on edge 3, output on edge 4.
    mdl_step();
    e = scan_q.pop_front();
    @(posedge clk); #1 csoc_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (dout !== 8'h00) begin
      fails++;
      $display("FAIL shift_early: data_o=%h expected 00", dout);
    end
    @(posedge clk); #1;
    tests++;
    if (dout !== e || dout !== 8'hA5) begin
      fails++;
      $display("FAIL shift_lat: data_o=%h expected A5", dout);
    end
    csoc_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_capture();
    se = 1'b0;
    unload("capture", 1);
    se = 1'b1; din = 8'h00;
    unload("unload_inv", 16);
  endtask

  task automatic func_read(input logic [7:0] b,
                           input logic [7:0] r);
    int n0, t0;
    n0 = wr_cnt;
    din = b;
    exp_q.push_back(r);
    @(posedge clk); #1 rd = 1'b1;
    t0 = cyc;
    repeat (4) @(posedge clk);
    #1 rd = 1'b0;
    for (int i = 0; i < 40 && wr_cnt == n0; i++)
      @(posedge clk);
    tests++;
    if (wr_cnt == n0) begin
      fails++;
      $display("FAIL func_timeout: no write_o for %h", b);
    end else if (wr_cyc - t0 != RESP_DELAY + 4) begin
      fails++;
      $display("FAIL func_lat: latency=%0d expected %0d",
               wr_cyc - t0, RESP_DELAY + 4);
    end
  endtask

  task automatic test_func();
    tm = 1'b0;
    repeat (4) @(posedge clk);
    func_read(8'h41, 8'h42);
    repeat (10) @(posedge clk);
    func_read(8'hFF, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (dout !== 8'h00) begin
      fails++;
      $display("FAIL func_hold: data_o=%h expected 00", dout);
    end
  endtask

  task automatic test_drop_abort();
    int n0;
    n0 = wr_cnt;
    din = 8'h10;
    exp_q.push_back(8'h11);
    @(posedge clk); #1 rd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rd = 1'b0; din = 8'h77;
    @(posedge clk); #1 rd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rd = 1'b0;
    repeat (30) @(posedge clk);
    tests++;
    if (wr_cnt - n0 != 1) begin
      fails++;
      $display("FAIL drop: writes=%0d expected 1", wr_cnt - n0);
    end
    n0 = wr_cnt;
    din = 8'h20;
    @(posedge clk); #1 rd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rd = 1'b0;
    @(posedge clk); #1 tm = 1'b1;
    repeat (30) @(posedge clk);
    tests++;
    if (wr_cnt != n0) begin
      fails++;
      $display("FAIL abort: writes=%0d expected 0", wr_cnt - n0);
    end
  endtask

  task automatic test_rst_mid();
    tm = 1'b1; se = 1'b1; din = 8'hFF;
    unload("fill", 16);
    tm = 1'b0;
    repeat (4) @(posedge clk);
    din = 8'h30;
    @(posedge clk); #1 rd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rd = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (write_o !== 1'b0 || dout !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid: write_o=%b data_o=%h expected 0/00",
               write_o, dout);
    end
    tm = 1'b1; se = 1'b1; din = 8'h00;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    unload("rst_unload", 16);
  endtask

  task automatic test_chip_reset();
    tm = 1'b1; se = 1'b1; din = 8'hFF;
    unload("pre_rstn", 8);
    @(posedge clk); #1 rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b1;
    mdl_clear();
    repeat (4) @(posedge clk);
    din = 8'h00;
    unload("post_rstn", 16);
`ifdef CSOC_RESP_SHIFT_CNT_EN
    tests++;
    if (scnt !== 16'd16) begin
      fails++;
      $display("FAIL shift_cnt: shift_cnt_o=%0d expected 16",
               scnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_shift();
    test_capture();
    test_func();
    test_drop_abort();
    test_rst_mid();
    test_chip_reset();
    repeat (5) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL resp_missing: %0d responses never seen",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csoc_scan_responder.md
Name: csoc_scan_responder

Overview:
Behavioural stand-in for the CSoC test port, i.e. the chip-side responder that the board tester drives. It holds 8 parallel scan chains that are shifted, captured and unloaded under tester control. In functional mode it answers tester bytes over the 8-bit strobe interface. It is used on a second board or in simulation to bring up the tester without real silicon.

Parameters:
CHAIN_LEN, 16, bits per scan chain (all 8 lanes); minimum 2.
RESP_DELAY, 4, clk cycles from accepted read strobe to the write strobe; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
csoc_clk_i  in  1  tester-driven scan clock, asynchronous to clk; sampled, never used as a clock
csoc_rstn_i  in  1  tester chip reset, active low; synchronized
csoc_test_se_i  in  1  scan enable
csoc_test_tm_i  in  1  test mode (1 = scan, 0 = functional)
csoc_uart_read_i  in  1  tester byte-valid strobe; data on csoc_data_i
csoc_data_i  in  8  scan-in per lane (bit k to chain k), or functional byte
csoc_uart_write_o  out  1  response strobe, one clk cycle
csoc_data_o  out  8  scan-out per lane (bit k = tail of chain k), or response byte

Behaviour:
- Reset (rst):
  - All chains are 0; FSM is F_IDLE; synchronizers are 0.
  - csoc_uart_write_o=0 and csoc_data_o=8'h00.
- Synchronization:
  - Every input except clk and rst passes through a 2-FF synchronizer.
  - A csoc_clk rising edge is detected from the synced value and its previous value.
  - The chain update happens on the 3rd clk edge after csoc_clk_i rises (fixed latency).
  - csoc_clk_i must stay high ≥3 clk cycles and low ≥3 clk cycles.
- Chip reset: synced csoc_rstn low clears the chains and the response register and forces F_IDLE. This happens every cycle while low, overrides everything else, and may occur mid-shift or mid-response.
- Scan shift (tm=1, se=1, on a detected edge):
  - Each chain k shifts by one: chain[0] is loaded with the synced data_i[k], and chain[i] is loaded with chain[i-1].
- Scan capture (tm=1, se=0, on a detected edge):
  - Each chain is loaded with the bitwise inverse of itself (a deterministic "functional" response).
- Scan-mode output: csoc_data_o[k] = chain k bit CHAIN_LEN-1, registered. It is valid 1 clk after the chain update.
- Functional mode (tm=0). FSM states and transitions:
  - F_IDLE: a synced read rising edge latches data_i into req, then go to F_WAIT with counter = RESP_DELAY-1.
  - F_WAIT: decrement the counter; at 0 go to F_RESP.
  - F_RESP: assert write_o for exactly 1 cycle with data_o = req+1 (8-bit wrap, FF→00), then go to F_IDLE.
  - Read edges seen in F_WAIT or F_RESP are dropped (no queue).
  - In functional mode, csoc_data_o holds the last response until the next one.
- Scan clock edges while tm=0 are ignored.
- Mode change:
  - tm rising while in F_WAIT or F_RESP aborts the FSM to F_IDLE, and write_o is not asserted.
  - Chains keep their contents across mode changes.
- csoc_data_o is muxed by the synced tm. The scan value is shown whenever tm=1.

Optional Feature:
CSOC_RESP_SHIFT_CNT_EN:
- Defined: adds output shift_cnt_o [15:0]. It counts detected shift edges (tm=1, se=1), saturates at FFFF, and is cleared by rst or synced csoc_rstn low. Capture edges do not count.
- Undefined: the port and the counter are absent.

Decomposition:
- Package csoc_resp_pkg holds:
  - the FSM state encoding (F_IDLE, F_WAIT, F_RESP);
  - the synchronizer depth constant (2);
  - the response increment constant (8'h01).
- Sub-module scan_lane (one CHAIN_LEN shift register with shift and invert-capture enables and a tail output) is instantiated 8 times.

Test Plan:
1. rst pulse mid-operation → write_o=0, data_o=00 immediately; a subsequent scan unload returns 00.
2. tm=1, se=1, data_i=A5, 16 csoc_clk pulses (4 clk high / 4 clk low) → data_o=A5; the chain update lands 3 clk after each rising edge.
3. After scenario 2: se=0, one csoc_clk pulse (capture) → data_o=5A; then se=1, data_i=00, 16 pulses → data_o sequence 5A…5A then 00 (the inverted contents are unloaded).
4. tm=0, data_i=41, read pulse → exactly one write_o cycle, RESP_DELAY+sync cycles later, data_o=42; data_i=FF → 00.
5. Read pulse, then a second read pulse during F_WAIT → exactly one response, for the first byte only. tm raised during F_WAIT → no write_o.
6. csoc_rstn_i low for 4 clk mid-shift after 8 pulses of FF → chains cleared; 16 pulses of 00 → data_o stays 00. With CSOC_RESP_SHIFT_CNT_EN, shift_cnt_o=16.
